stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_seq_pkg.sv | 35 +++
 rtl/stack_alu.sv | 26 ++
 rtl/stack_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
`default_nettype none
// ============================================================================
// stack_seq_pkg : opcodes, state encoding, error codes, default widths
// Rev 1.0
// ============================================================================
package stack_seq_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_AW  = 8;
  localparam int DEF_PCW = 5;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSH  = 8'h01;
  localparam logic [7:0] OP_PUSHC = 8'h02;
  localparam logic [7:0] OP_POP   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h04;
  localparam logic [7:0] OP_SUB   = 8'h05;
  localparam logic [7:0] OP_HALT  = 8'h06;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_POPA   = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/stack_alu.sv
`default_nettype none
// ============================================================================
// stack_alu : combinational modulo add/sub with signed-overflow detect
// Rev 1.0
// ============================================================================
module stack_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] result,
  output logic          ovf
);

  always_comb begin
    result = sub ? (a - b) : (a + b);
    // Subtraction overflows when operand signs differ, addition when they match
    if (sub)
      ovf = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
    else
      ovf = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
  end

endmodule
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// stack_sequencer : micro-sequencer driving an external stack and data memory
// Rev 1.0
// ============================================================================
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int PCW = DEF_PCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic           ovf,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_data,
  output logic [AW-1:0]  dmem_addr,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           stk_push,
  output logic           stk_pop,
  output logic [DW-1:0]  stk_wdata,
  input  logic [DW-1:0]  stk_top,
  input  logic           stk_empty,
  input  logic           stk_full
);

  logic [2:0]     r_state;
  logic [PCW-1:0] r_pc;
  logic [1:0]     r_err_code;
  logic           r_ovf;
  logic           r_is_sub;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;

  logic [7:0]     w_op;
  logic [AW-1:0]  w_operand;
  logic [2:0]     w_next;
  logic           w_accept;
  logic           w_pc_inc;
  logic           w_err_set;
  logic [1:0]     w_err_code;
  logic           w_lat_a;
  logic           w_lat_b;
  logic           w_push;
  logic           w_pop;
  logic           w_we;
  logic           w_ovf_set;
  logic [AW-1:0]  w_daddr;
  logic [DW-1:0]  w_dwdata;
  logic [DW-1:0]  w_swdata;
  logic [DW-1:0]  w_alu_res;
  logic           w_alu_ovf;

  assign w_op      = imem_data[15:8];
  assign w_operand = imem_data[AW-1:0];

  stack_alu #(.DW(DW)) u_alu (
    .a      (r_a),
    .b      (r_b),
    .sub    (r_is_sub),
    .result (w_alu_res),
    .ovf    (w_alu_ovf)
  );

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_pc_inc   = 1'b0;
    w_err_set  = 1'b0;
    w_err_code = ERR_NONE;
    w_lat_a    = 1'b0;
    w_lat_b    = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_we       = 1'b0;
    w_ovf_set  = 1'b0;
    w_daddr    = '0;
    w_dwdata   = '0;
    w_swdata   = '0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_NOP: begin
            w_pc_inc = 1'b1;
            w_next   = S_FETCH;
          end
          OP_PUSHC: begin
            if (stk_full) begin
              w_err_set = 1'b1; w_err_code = ERR_OVERFLOW; w_next = S_ERROR;
            end else begin
              w_push   = 1'b1;
              w_swdata = DW'(w_operand);
              w_pc_inc = 1'b1;
              w_next   = S_FETCH;
            end
          end
          OP_PUSH: begin
            w_daddr = w_operand;
            w_next  = S_MEMRD;
          end
          OP_POP: begin
            if (stk_empty) begin
              w_err_set = 1'b1; w_err_code = ERR_UNDERFLOW; w_next = S_ERROR;
            end else begin
              w_pop    = 1'b1;
              w_we     = 1'b1;
              w_daddr  = w_operand;
              w_dwdata = stk_top;
              w_pc_inc = 1'b1;
              w_next   = S_FETCH;
            end
          end
          OP_ADD, OP_SUB: begin
            if (stk_empty) begin
              w_err_set = 1'b1; w_err_code = ERR_UNDERFLOW; w_next = S_ERROR;
            end else begin
              w_lat_b = 1'b1;
              w_pop   = 1'b1;
              w_next  = S_POPA;
            end
          end
          OP_HALT: w_next = S_DONE;
          default: begin
            w_err_set = 1'b1; w_err_code = ERR_ILLEGAL; w_next = S_ERROR;
          end
        endcase
      end
      S_MEMRD: begin
        if (stk_full) begin
          w_err_set = 1'b1; w_err_code = ERR_OVERFLOW; w_next = S_ERROR;
        end else begin
          w_push   = 1'b1;
          w_swdata = dmem_rdata;
          w_pc_inc = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_POPA: begin
        // First pop already happened in DECODE and is deliberately not undone
        if (stk_empty) begin
          w_err_set = 1'b1; w_err_code = ERR_UNDERFLOW; w_next = S_ERROR;
        end else begin
          w_lat_a = 1'b1;
          w_pop   = 1'b1;
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (stk_full) begin
          w_err_set = 1'b1; w_err_code = ERR_OVERFLOW; w_next = S_ERROR;
        end else begin
          w_push    = 1'b1;
          w_swdata  = w_alu_res;
          w_ovf_set = w_alu_ovf;
          w_pc_inc  = 1'b1;
          w_next    = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_err_code <= ERR_NONE;
      r_ovf      <= 1'b0;
      r_is_sub   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pc       <= '0;
        r_err_code <= ERR_NONE;
        r_ovf      <= 1'b0;
      end else begin
        if (w_pc_inc)  r_pc       <= r_pc + 1'b1;
        if (w_err_set) r_err_code <= w_err_code;
        if (w_ovf_set) r_ovf      <= 1'b1;
      end
      if (w_lat_b) begin
        r_b      <= stk_top;
        r_is_sub <= (w_op == OP_SUB);
      end
      if (w_lat_a) r_a <= stk_top;
    end
  end

  assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_MEMRD) ||
                      (r_state == S_POPA)  || (r_state == S_EXEC);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERROR);
  assign err_code   = r_err_code;
  assign ovf        = r_ovf;
  assign imem_addr  = r_pc;
  assign dmem_addr  = w_daddr;
  assign dmem_wdata = w_dwdata;
  assign stk_wdata  = w_swdata;
  // Strobes are masked by rst so a reset mid-instruction never leaks a side effect
  assign dmem_we    = w_we   & ~rst;
  assign stk_push   = w_push & ~rst;
  assign stk_pop    = w_pop  & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// tb_stack_sequencer : directed self-checking bench with memory/stack models
// Rev 1.0
// ============================================================================
module tb_stack_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, ovf;
  logic [1:0]  err_code;
  logic [4:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic        stk_push, stk_pop;
  logic [7:0]  stk_wdata, stk_top;
  logic        stk_empty, stk_full;

  logic [15:0] imem [32];
  logic [7:0]  dmem [256];
  logic [7:0]  stk  [DEPTH];
  int          sp;
  int          push_cnt, pop_cnt, we_cnt, both_cnt;
  logic        clr_env = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .ovf(ovf), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_top(stk_top), .stk_empty(stk_empty), .stk_full(stk_full)
  );

  always @(posedge clk) imem_data <= imem[imem_addr];

  always @(posedge clk) begin
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
  end

  assign stk_top   = (sp > 0) ? stk[sp-1] : 8'h00;
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);

  always @(posedge clk) begin
    if (clr_env) begin
      sp <= 0; push_cnt <= 0; pop_cnt <= 0; we_cnt <= 0; both_cnt <= 0;
    end else begin
      if (stk_push && sp < DEPTH) begin
        stk[sp] <= stk_wdata;
        sp <= sp + 1;
      end else if (stk_pop && sp > 0) begin
        sp <= sp - 1;
      end
      if (stk_push) push_cnt <= push_cnt + 1;
      if (stk_pop)  pop_cnt  <= pop_cnt + 1;
      if (dmem_we)  we_cnt   <= we_cnt + 1;
      if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_env();
    clr_env = 1'b1;
    tick();
    clr_env = 1'b0;
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 32; i++) imem[i] = 16'h0600;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // cycles counts edges from the one that samples start until done|err shows
  task automatic run_to_halt(output int cycles);
    cycles = 1;
    pulse_start();
    while (!(done || err) && cycles < 300) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (!(done || err)) begin
      n_fail++;
      $display("FAIL halt_timeout: busy=%b after %0d cycles, required done or err", busy, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({busy, done, err, err_code, ovf, dmem_we, stk_push, stk_pop} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000000",
               {busy, done, err, err_code, ovf, dmem_we, stk_push, stk_pop});
    end
    n_tests++;
    if ({imem_addr, dmem_addr, dmem_wdata, stk_wdata} !== 29'b0) begin
      n_fail++;
      $display("FAIL reset_buses: imem_addr=%h dmem_addr=%h dmem_wdata=%h stk_wdata=%h required 0",
               imem_addr, dmem_addr, dmem_wdata, stk_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_program();
    int cyc;
    fill_imem();
    imem[0] = 16'h0205; imem[1] = 16'h0217; imem[2]  = 16'h0400; imem[3] = 16'h0300;
    imem[4] = 16'h0100; imem[5] = 16'h0100; imem[6]  = 16'h0400; imem[7] = 16'h020C;
    imem[8] = 16'h0500; imem[9] = 16'h0301; imem[10] = 16'h0600;
    clear_env();
    run_to_halt(cyc);
    n_tests++;
    if (dmem[1] !== 8'd44) begin
      n_fail++; $display("FAIL prog_mem1: got %0d required 44", dmem[1]);
    end
    n_tests++;
    if (dmem[0] !== 8'd28) begin
      n_fail++; $display("FAIL prog_mem0: got %0d required 28", dmem[0]);
    end
    n_tests++;
    if ({done, err, ovf, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL prog_status: done/err/ovf/busy=%b required 1000", {done, err, ovf, busy});
    end
    n_tests++;
    if (sp !== 0 || both_cnt !== 0) begin
      n_fail++; $display("FAIL prog_stack: depth=%0d both_strobes=%0d required 0 and 0", sp, both_cnt);
    end
  endtask

  task automatic test_cycle_count();
    int cyc;
    fill_imem();
    imem[0] = 16'h0203; imem[1] = 16'h0600;
    clear_env();
    run_to_halt(cyc);
    n_tests++;
    if (cyc !== 5 || done !== 1'b1) begin
      n_fail++; $display("FAIL cycle_count: got %0d cycles done=%b required 5 and 1", cyc, done);
    end
    n_tests++;
    if (push_cnt !== 1 || stk[0] !== 8'd3) begin
      n_fail++; $display("FAIL push_width: push cycles=%0d value=%0d required 1 and 3", push_cnt, stk[0]);
    end
  endtask

  task automatic test_ovf_flag();
    int cyc;
    fill_imem();
    imem[0] = 16'h0264; imem[1] = 16'h0264; imem[2] = 16'h0400; imem[3] = 16'h0302;
    clear_env();
    run_to_halt(cyc);
    n_tests++;
    if (dmem[2] !== 8'hC8) begin
      n_fail++; $display("FAIL ovf_mem2: got %h required c8", dmem[2]);
    end
    n_tests++;
    if (ovf !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: ovf=%b done=%b required 1 and 1", ovf, done);
    end
  endtask

  task automatic test_underflow();
    int cyc;
    fill_imem();
    imem[0] = 16'h0207; imem[1] = 16'h0400;
    clear_env();
    run_to_halt(cyc);
    n_tests++;
    if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL underflow_code: err=%b code=%0d busy=%b required 1,1,0", err, err_code, busy);
    end
    n_tests++;
    if (imem_addr !== 5'd1 || pop_cnt !== 1) begin
      n_fail++; $display("FAIL underflow_pc: pc=%0d pops=%0d required 1 and 1", imem_addr, pop_cnt);
    end
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || err !== 1'b0 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL restart: busy=%b err=%b code=%0d required 1,0,0", busy, err, err_code);
    end
    run_to_halt(cyc);
  endtask

  task automatic test_illegal();
    int cyc;
    fill_imem();
    imem[0] = 16'hFF00;
    clear_env();
    run_to_halt(cyc);
    n_tests++;
    if (err_code !== 2'd3 || err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_code: code=%0d err=%b required 3 and 1", err_code, err);
    end
    n_tests++;
    if (push_cnt + pop_cnt + we_cnt !== 0) begin
      n_fail++; $display("FAIL illegal_strobes: got %0d strobes required 0", push_cnt + pop_cnt + we_cnt);
    end
  endtask

  task automatic test_stack_full();
    int cyc;
    fill_imem();
    for (int i = 0; i < 5; i++) imem[i] = {8'h02, 8'(i + 1)};
    clear_env();
    run_to_halt(cyc);
    n_tests++;
    if (err_code !== 2'd2 || imem_addr !== 5'd4) begin
      n_fail++; $display("FAIL full_code: code=%0d pc=%0d required 2 and 4", err_code, imem_addr);
    end
    n_tests++;
    if (push_cnt !== 4 || stk[DEPTH-1] !== 8'd4) begin
      n_fail++; $display("FAIL full_push: pushes=%0d top=%0d required 4 and 4", push_cnt, stk[DEPTH-1]);
    end
  endtask

  task automatic test_reset_mid();
    fill_imem();
    imem[0] = 16'h0103;
    clear_env();
    pulse_start();
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b1 || stk_push !== 1'b1) begin
      n_fail++; $display("FAIL memrd_reach: busy=%b push=%b required 1 and 1", busy, stk_push);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (stk_push !== 1'b0) begin
      n_fail++; $display("FAIL reset_push_mask: push=%b required 0", stk_push);
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, err, err_code, ovf, dmem_we, stk_push, stk_pop} !== 9'b0 ||
        {imem_addr, dmem_addr, dmem_wdata, stk_wdata} !== 29'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: flags=%b pc=%0d required all 0",
                         {busy, done, err, err_code, ovf, dmem_we, stk_push, stk_pop}, imem_addr);
    end
    n_tests++;
    if (push_cnt !== 0 || sp !== 0) begin
      n_fail++; $display("FAIL reset_mid_push: pushes=%0d depth=%0d required 0 and 0", push_cnt, sp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    fill_imem();
    test_reset();
    test_program();
    test_cycle_count();
    test_ovf_flag();
    test_underflow();
    test_illegal();
    test_stack_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
